stage_perf_monitor: RTL
=======================

Name: stage_perf_monitor

Overview:
- Downstream consumer of the pipeline-stage valid/ready status pulses that feed the debug flag register.
- Turns the SpMM, DMVM, softmax and aggregator start/done pulses into per-stage performance statistics: busy cycles, run count, last latency and max latency.
- Stats are read through a one-cycle-latency register read port, so software or the ILA can read timing instead of sticky flags.

Parameters:
- CNT_W, 32, width of busy-cycle and latency counters (saturating)
- RUN_W, 16, width of run counter (saturating)
- NUM_STAGES, 4, stages monitored: 0=spmm, 1=dmvm, 2=sm, 3=aggr

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_i  in  NUM_STAGES  per-stage start pulse (stage *_vld_i), bit k = stage k
- done_i  in  NUM_STAGES  per-stage done pulse (stage *_rdy_i)
- freeze_i  in  1  level; holds all stat registers
- clear_i  in  1  synchronous clear pulse
- rd_en_i  in  1  read request
- rd_addr_i  in  4  {stage[1:0], field[1:0]}; field 0=busy, 1=runs, 2=last_lat, 3=max_lat
- rd_data_o  out  32  read data, zero-extended
- rd_vld_o  out  1  read data valid
- err_o  out  NUM_STAGES  sticky overlap error per stage

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-high (rst). All stats, latency counters, err_o, rd_data_o and rd_vld_o go to 0. All FSMs go to IDLE. Reset mid-run drops the in-flight run.
- Per-stage FSM: IDLE, BUSY.
- IDLE + start, no done: go to BUSY; lat_cnt <= 1.
- IDLE + start + done in the same cycle: record a run with latency 0; stay IDLE.
- IDLE + done alone: ignored.
- BUSY, no done: lat_cnt increments (saturating); busy increments.
- BUSY + done: record a run with latency lat_cnt; busy increments for this final cycle; go to IDLE. With start also high that cycle: go to BUSY with lat_cnt <= 1 (back-to-back run).
- BUSY + start without done: err_o[k] set (sticky); the start is ignored and the run continues.
- Latency definition: start at cycle t and done at cycle t+L gives last_lat = L. Busy then equals the sum of L over runs.
- Record a run:
  - runs += 1, saturating at 2^RUN_W-1
  - last_lat <= L
  - max_lat <= max(max_lat, L)
- Busy saturates at 2^CNT_W-1.
- freeze_i high: busy, runs, last_lat and max_lat are not written. FSM, lat_cnt and err_o keep tracking. A run completing while frozen is lost from the stats.
- clear_i: zeroes stats and err_o and forces all FSMs to IDLE. It has priority over start/done/freeze in the same cycle.
- Read port:
  - rd_en_i at cycle t gives rd_vld_o=1 and rd_data_o at t+1.
  - rd_vld_o is 0 otherwise, and rd_data_o holds its last value.
  - The read returns the register value before any update in cycle t.
  - Back-to-back reads are allowed, one per cycle.
  - A read in the same cycle as clear_i returns the pre-clear value.
- Latency: stats update 1 cycle after the done pulse.

Decomposition:
- Package gat_dbg_pkg holds:
  - NUM_STAGES and stage index enum (STG_SPMM, STG_DMVM, STG_SM, STG_AGGR)
  - field enum (FLD_BUSY, FLD_RUNS, FLD_LAST, FLD_MAX)
  - RD_ADDR_W=4
  - FSM state typedef (IDLE, BUSY)
- Sub-module stage_perf_counter: one FSM plus its four stats and err bit. Instantiated NUM_STAGES times by a generate loop. Top level holds only the read mux and output register.

Test Plan:
- Single run: start[0] at cycle 10, done[0] at cycle 15 → read 0x2 = 5, 0x3 = 5, 0x1 = 1, 0x0 = 5; rd_vld_o exactly 1 cycle after each rd_en_i.
- Back-to-back runs: stage 2 with latencies 3, then 7 (done+start coincident), then 4 → runs=3, last=4, max=7, busy=14; err_o=0.
- Zero latency and overlap:
  - start+done same cycle on stage 1 from IDLE → runs=1, last=0.
  - Second start on stage 3 while BUSY → err_o[3]=1, and that run's latency counts from the first start.
- Freeze/clear:
  - Run of 6 on stage 0 while freeze_i=1 → stats unchanged.
  - clear_i together with done[0] → all reads 0, err_o=0, FSM IDLE.
- Saturation/reset: force busy near 2^32-1 or run 70000 cycles with RUN_W=16 → value pins at max, no wrap. Assert rst mid-run → all reads 0; the next done is ignored.

Source files
------------

// File: rtl/stage_perf_monitor_pkg.sv
// Shared types for the pipeline-stage performance monitor: stage and
// read-field encodings, read address width and the per-stage FSM states.
package gat_dbg_pkg;

  localparam int NUM_STAGES = 4;
  localparam int RD_ADDR_W  = 4;

  typedef enum logic [1:0] {
    STG_SPMM = 2'd0,
    STG_DMVM = 2'd1,
    STG_SM   = 2'd2,
    STG_AGGR = 2'd3
  } stage_e;

  typedef enum logic [1:0] {
    FLD_BUSY = 2'd0,
    FLD_RUNS = 2'd1,
    FLD_LAST = 2'd2,
    FLD_MAX  = 2'd3
  } field_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/stage_perf_monitor_if.sv
// Bundle of stage status pulses, control levels, the stats read port and
// the sticky overlap error flags. The monitor is the slave side.
interface stage_perf_monitor_if #(
  parameter int NUM_STAGES = 4
);

  logic [NUM_STAGES-1:0]              start_i;
  logic [NUM_STAGES-1:0]              done_i;
  logic                               freeze_i;
  logic                               clear_i;
  logic                               rd_en_i;
  logic [gat_dbg_pkg::RD_ADDR_W-1:0]  rd_addr_i;
  logic [31:0]                        rd_data_o;
  logic                               rd_vld_o;
  logic [NUM_STAGES-1:0]              err_o;

  modport master (
    output start_i, done_i, freeze_i, clear_i, rd_en_i, rd_addr_i,
    input  rd_data_o, rd_vld_o, err_o
  );

  modport slave (
    input  start_i, done_i, freeze_i, clear_i, rd_en_i, rd_addr_i,
    output rd_data_o, rd_vld_o, err_o
  );

endinterface

// File: rtl/stage_perf_monitor_counter.sv
// One stage's IDLE/BUSY tracker with its latency counter and the four
// statistics it feeds (busy cycles, run count, last and max latency),
// plus the sticky overlap error bit.
module stage_perf_counter
  import gat_dbg_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int RUN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             done_i,
  input  logic             freeze_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] busy_o,
  output logic [RUN_W-1:0] runs_o,
  output logic [CNT_W-1:0] last_o,
  output logic [CNT_W-1:0] max_o,
  output logic             err_o
);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (&v) ? v : v + RUN_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] busy_q, busy_d;
  logic [RUN_W-1:0] runs_q, runs_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             err_q, err_d;
  logic             rec;
  logic             busy_inc;
  logic [CNT_W-1:0] rec_lat;

  // Next-state: FSM transitions, run recording gated by freeze, clear wins
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    busy_d   = busy_q;
    runs_d   = runs_q;
    last_d   = last_q;
    max_d    = max_q;
    err_d    = err_q;
    rec      = 1'b0;
    busy_inc = 1'b0;
    rec_lat  = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i && done_i) begin
          // Zero-latency run: recorded without ever entering BUSY.
          rec     = 1'b1;
          rec_lat = '0;
        end else if (start_i) begin
          state_d = BUSY;
          lat_d   = CNT_W'(1);
        end
      end
      BUSY: begin
        busy_inc = 1'b1;
        if (done_i) begin
          rec     = 1'b1;
          rec_lat = lat_q;
          if (start_i) begin
            lat_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          lat_d = sat_inc_cnt(lat_q);
          // A second start mid-run is flagged and otherwise ignored.
          if (start_i) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!freeze_i) begin
      if (busy_inc) begin
        busy_d = sat_inc_cnt(busy_q);
      end
      if (rec) begin
        runs_d = sat_inc_run(runs_q);
        last_d = rec_lat;
        max_d  = (rec_lat > max_q) ? rec_lat : max_q;
      end
    end

    if (clear_i) begin
      state_d = IDLE;
      lat_d   = '0;
      busy_d  = '0;
      runs_d  = '0;
      last_d  = '0;
      max_d   = '0;
      err_d   = 1'b0;
    end
  end

  // State and statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      busy_q  <= '0;
      runs_q  <= '0;
      last_q  <= '0;
      max_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      runs_q  <= runs_d;
      last_q  <= last_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = busy_q;
  assign runs_o = runs_q;
  assign last_o = last_q;
  assign max_o  = max_q;
  assign err_o  = err_q;

endmodule

// File: rtl/stage_perf_monitor.sv
// Per-stage performance monitor: one counter block per pipeline stage and
// a registered read mux giving one-cycle-latency access to every stat.
module stage_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int RUN_W      = 16,
  parameter int NUM_STAGES = gat_dbg_pkg::NUM_STAGES
) (
  input logic                 clk,
  input logic                 rst,
  stage_perf_monitor_if.slave bus
);

  import gat_dbg_pkg::*;

  logic [CNT_W-1:0]      busy_w [NUM_STAGES];
  logic [RUN_W-1:0]      runs_w [NUM_STAGES];
  logic [CNT_W-1:0]      last_w [NUM_STAGES];
  logic [CNT_W-1:0]      max_w  [NUM_STAGES];
  logic [NUM_STAGES-1:0] err_w;
  logic [31:0]           rd_mux;
  logic [31:0]           rd_data_q;
  logic                  rd_vld_q;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    stage_perf_counter #(
      .CNT_W (CNT_W),
      .RUN_W (RUN_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .start_i  (bus.start_i[k]),
      .done_i   (bus.done_i[k]),
      .freeze_i (bus.freeze_i),
      .clear_i  (bus.clear_i),
      .busy_o   (busy_w[k]),
      .runs_o   (runs_w[k]),
      .last_o   (last_w[k]),
      .max_o    (max_w[k]),
      .err_o    (err_w[k])
    );
  end

  // Select the addressed stat from the current (pre-update) register values
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (bus.rd_addr_i[3:2] == 2'(k)) begin
        unique case (field_e'(bus.rd_addr_i[1:0]))
          FLD_BUSY: rd_mux = 32'(busy_w[k]);
          FLD_RUNS: rd_mux = 32'(runs_w[k]);
          FLD_LAST: rd_mux = 32'(last_w[k]);
          FLD_MAX:  rd_mux = 32'(max_w[k]);
          default:  rd_mux = '0;
        endcase
      end
    end
  end

  // Read response register; data holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= bus.rd_en_i;
      if (bus.rd_en_i) begin
        rd_data_q <= rd_mux;
      end
    end
  end

  assign bus.rd_data_o = rd_data_q;
  assign bus.rd_vld_o  = rd_vld_q;
  assign bus.err_o     = err_w;

endmodule
